// File: rtl/mem_data_queue.sv
// Load-data queue between the data-memory read port and writeback, with byte/half/word
// extraction and sign/zero extension on the head entry. Optional bypass: MEM_DATA_QUEUE_BYPASS_EN.
module mem_data_queue #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   localparam int OFF_W = $clog2(DATA_W / 8),
   localparam int CNT_W = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] read_data,
   input  logic [1:0]        load_size,
   input  logic              load_signed,
   input  logic [OFF_W-1:0]  byte_offset,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [1:0]        size;
      logic              sgn;
      logic [OFF_W-1:0]  off;
   } entry_t;

   entry_t            mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   entry_t            head;
   logic              enq, deq, bypass, q_valid;

   function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] d,
                                              input logic [1:0]        sz,
                                              input logic              sg,
                                              input logic [OFF_W-1:0]  off);
      logic [DATA_W-1:0] r;
      logic [7:0]        b;
      logic [15:0]       h;
      logic [31:0]       w;
      int unsigned       bi, hi, wi;
      bi = 32'(off);
      hi = bi >> 1;
      wi = bi >> 2;
      b  = d[bi*8 +: 8];
      h  = d[hi*16 +: 16];
      w  = d[wi*32 +: 32];
      case (sz)
         2'd0: begin
            r       = {DATA_W{sg & b[7]}};
            r[7:0]  = b;
         end
         2'd1: begin
            r       = {DATA_W{sg & h[15]}};
            r[15:0] = h;
         end
         2'd2: begin
            r       = {DATA_W{sg & w[31]}};
            r[31:0] = w;
         end
         default: r = d;
      endcase
      return r;
   endfunction

   // Explicit wrap so non-power-of-2 depths cycle correctly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head     = mem_q[rd_ptr_q];
   assign in_ready = (count_q < CNT_W'(DEPTH)) && !flush && !reset;
   assign q_valid  = (count_q != '0) && !flush && !reset;

`ifdef MEM_DATA_QUEUE_BYPASS_EN
   // in_ready already folds in !flush and !reset, and is always high when empty.
   assign bypass = (count_q == '0) && in_valid && out_ready && in_ready;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = q_valid || bypass;
   assign enq       = in_valid && in_ready && !bypass;
   assign deq       = q_valid && out_ready;
   assign count     = count_q;

   always_comb begin
      data_out = '0;
      if (bypass)
         data_out = fmt(read_data, load_size, load_signed, byte_offset);
      else if (q_valid)
         data_out = fmt(head.data, head.size, head.sgn, head.off);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq) mem_q[wr_ptr_q] <= '{data: read_data, size: load_size,
                                        sgn: load_signed, off: byte_offset};
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_mem_data_queue.sv
// Scoreboard bench for mem_data_queue (DATA_W=32, DEPTH=2); expectations follow
// MEM_DATA_QUEUE_BYPASS_EN when it is defined for the build.
module tb_mem_data_queue;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, in_ready;
   logic [31:0] read_data, data_out;
   logic [1:0]  load_size, byte_offset, count;
   logic        load_signed, out_valid, out_ready;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] sb [$];
   logic [31:0] mon_exp;
   bit          mon_en = 0;

   always #5 clock = ~clock;

   mem_data_queue #(.DATA_W(32), .DEPTH(2)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .read_data(read_data), .load_size(load_size),
      .load_signed(load_signed), .byte_offset(byte_offset),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .count(count)
   );

   // Scoreboard side: every accepted output pops one expected value.
   always @(negedge clock) begin
      if (mon_en) begin
         if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected: data_out=%h with nothing expected", data_out);
            end else begin
               mon_exp = sb.pop_front();
               if (data_out !== mon_exp) begin
                  miscompares++;
                  $display("FAIL sb_data: got %h expected %h", data_out, mon_exp);
               end
            end
         end else if (!out_valid) begin
            vectors++;
            if (data_out !== 32'h0) begin
               miscompares++;
               $display("FAIL empty_zero: data_out=%h expected 00000000", data_out);
            end
         end
         vectors++;
         if (count > 2'd2) begin
            miscompares++;
            $display("FAIL count_bound: count=%0d expected <= 2", count);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] sz, input logic sg,
                       input logic [1:0] off, input logic [31:0] exp);
      bit done = 0;
      read_data   = d;
      load_size   = sz;
      load_signed = sg;
      byte_offset = off;
      in_valid    = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (in_ready) begin
            sb.push_back(exp);
            done = 1;
         end
         cyc();
      end
      in_valid = 1'b0;
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL push_timeout: in_ready=%b expected 1 within 20 cycles", in_ready);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (sb.size() != 0 || count != 2'd0); i++) cyc();
      vectors++;
      if (sb.size() != 0 || count !== 2'd0) begin
         miscompares++;
         $display("FAIL drain: count=%0d pending=%0d expected 0/0", count, sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      vectors++;
      if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state: count=%0d ov=%b ir=%b do=%h expected 0/0/1/00000000",
                  count, out_valid, in_ready, data_out);
      end
      mon_en = 1;
      cyc();
   endtask

   task automatic test_byte_load();
      out_ready = 1'b1;
      push(32'h80FF7F01, 2'd0, 1'b1, 2'd3, 32'hFFFFFF80);
      push(32'h80FF7F01, 2'd0, 1'b0, 2'd3, 32'h00000080);
      push(32'h80FF7F01, 2'd0, 1'b1, 2'd1, 32'h0000007F);
      drain();
   endtask

   task automatic test_half_word();
      out_ready = 1'b1;
      push(32'h1234ABCD, 2'd1, 1'b1, 2'd2, 32'h00001234);
      push(32'h1234ABCD, 2'd1, 1'b1, 2'd0, 32'hFFFFABCD);
      push(32'h1234ABCD, 2'd2, 1'b1, 2'd0, 32'h1234ABCD);
      push(32'h1234ABCD, 2'd1, 1'b0, 2'd1, 32'h0000ABCD);
      push(32'h1234ABCD, 2'd0, 1'b1, 2'd0, 32'hFFFFFFCD);
      push(32'h1234ABCD, 2'd3, 1'b1, 2'd2, 32'h1234ABCD);
      drain();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(32'hA1A1A1A1, 2'd2, 1'b0, 2'd0, 32'hA1A1A1A1);
      push(32'hB2B2B2B2, 2'd2, 1'b0, 2'd0, 32'hB2B2B2B2);
      #1;
      vectors++;
      if (count !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 32'hA1A1A1A1) begin
         miscompares++;
         $display("FAIL full_state: count=%0d ir=%b ov=%b do=%h expected 2/0/1/a1a1a1a1",
                  count, in_ready, out_valid, data_out);
      end
      read_data = 32'hC3C3C3C3;
      load_size = 2'd2;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         vectors++;
         if (in_ready !== 1'b0 || count !== 2'd2 || data_out !== 32'hA1A1A1A1) begin
            miscompares++;
            $display("FAIL stall_hold: ir=%b count=%0d do=%h expected 0/2/a1a1a1a1",
                     in_ready, count, data_out);
         end
      end
      cyc();
      out_ready = 1'b1;
      push(32'hC3C3C3C3, 2'd2, 1'b0, 2'd0, 32'hC3C3C3C3);
      drain();
   endtask

   task automatic test_push_pop();
      logic [31:0] d;
      int          off;
      out_ready = 1'b0;
      push(32'h5A5A0000, 2'd2, 1'b0, 2'd0, 32'h5A5A0000);
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         d = $urandom;
         if (i % 2 == 0) begin
            push(d, 2'd2, 1'b0, 2'd0, d);
         end else begin
            off = i % 4;
            push(d, 2'd0, 1'b0, 2'(off), {24'h0, d[8*off +: 8]});
         end
         vectors++;
         if (count !== 2'd1) begin
            miscompares++;
            $display("FAIL push_pop_count: iter %0d count=%0d expected 1", i, count);
         end
      end
      drain();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      push(32'h01010101, 2'd2, 1'b0, 2'd0, 32'h01010101);
      push(32'h02020202, 2'd2, 1'b0, 2'd0, 32'h02020202);
      read_data = 32'hDDDDDDDD;
      in_valid  = 1'b1;
      flush     = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_cycle: ov=%b ir=%b expected 0/0", out_valid, in_ready);
      end
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      #1;
      vectors++;
      if (count !== 2'd0 || data_out !== 32'h0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_after: count=%0d do=%h ov=%b expected 0/00000000/0",
                  count, data_out, out_valid);
      end
      cyc();
      out_ready = 1'b1;
      repeat (3) cyc();
      push(32'hE5E5E5E5, 2'd2, 1'b0, 2'd0, 32'hE5E5E5E5);
      drain();

      out_ready = 1'b0;
      push(32'h03030303, 2'd2, 1'b0, 2'd0, 32'h03030303);
      push(32'h04040404, 2'd2, 1'b0, 2'd0, 32'h04040404);
      read_data = 32'hDDDDDDDD;
      in_valid  = 1'b1;
      reset     = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_cycle: ov=%b ir=%b expected 0/0", out_valid, in_ready);
      end
      cyc();
      reset    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      #1;
      vectors++;
      if (count !== 2'd0 || data_out !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_after: count=%0d do=%h ov=%b ir=%b expected 0/00000000/0/1",
                  count, data_out, out_valid, in_ready);
      end
      cyc();
      out_ready = 1'b1;
      repeat (3) cyc();
      push(32'hF6F6F6F6, 2'd2, 1'b0, 2'd0, 32'hF6F6F6F6);
      drain();
   endtask

   task automatic test_latency();
      out_ready   = 1'b1;
      read_data   = 32'hDEADBEEF;
      load_size   = 2'd2;
      load_signed = 1'b0;
      byte_offset = 2'd0;
      in_valid    = 1'b1;
      #1;
`ifdef MEM_DATA_QUEUE_BYPASS_EN
      vectors++;
      if (out_valid !== 1'b1 || data_out !== 32'hDEADBEEF || count !== 2'd0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bypass_same: ov=%b do=%h count=%0d ir=%b expected 1/deadbeef/0/1",
                  out_valid, data_out, count, in_ready);
      end
      sb.push_back(32'hDEADBEEF);
      cyc();
      in_valid = 1'b0;
      #1;
      vectors++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bypass_after: count=%0d ov=%b expected 0/0", count, out_valid);
      end
`else
      vectors++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL latency_same: ov=%b count=%0d ir=%b expected 0/0/1",
                  out_valid, count, in_ready);
      end
      sb.push_back(32'hDEADBEEF);
      cyc();
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || data_out !== 32'hDEADBEEF || count !== 2'd1) begin
         miscompares++;
         $display("FAIL latency_next: ov=%b do=%h count=%0d expected 1/deadbeef/1",
                  out_valid, data_out, count);
      end
`endif
      cyc();
      drain();
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      read_data   = '0;
      load_size   = '0;
      load_signed = 1'b0;
      byte_offset = '0;
      out_ready   = 1'b0;
      test_reset();
      test_byte_load();
      test_half_word();
      test_backpressure();
      test_push_pop();
      test_flush();
      test_latency();
      mon_en = 0;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: %0d entries pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
